gcd_seq_ctrl: RTL
=================

# gcd_seq_ctrl

Parametrised sequencer for the GCD register-file/ALU datapath. It generates the control word that the datapath wrapper currently receives from outside: `raddr1`, `raddr2`, `wen`, `waddr`, `wdsrc`, `func` and `constant`. It runs subtractive Euclid on two operands, driven by the ALU `is_zero` and `is_neg` flags. A start/busy/done handshake and an iteration watchdog replace the old free-running pass-through.

## Interface
- `DATA_W`, 32, operand/constant width
- `ADDR_W`, 4, register-file address width
- `FUNC_W`, 4, ALU function code width
- `REG_A`, 0, register holding operand A / result
- `REG_B`, 1, register holding operand B
- `FUNC_SUB`, 1, ALU code for rs1 − rs2
- `FUNC_NOP`, 0, ALU code driven when idle
- `ITER_W`, 16, watchdog counter width; limit = 2^ITER_W − 1 compare cycles
- `clk  in  1  clock`
- `rst_n  in  1  asynchronous active-low reset`
- `start  in  1  request; sampled only in IDLE`
- `op_a, op_b  in  DATA_W  operands, latched when start is accepted`
- `is_zero  in  1  ALU result == 0 (combinational, same cycle)`
- `is_neg  in  1  borrow of rs1 − rs2, unsigned (rs1 < rs2)`
- `raddr1, raddr2  out  ADDR_W  read addresses`
- `wen  out  1  register-file write enable`
- `waddr  out  ADDR_W  write address`
- `wdsrc  out  1  1 = write constant, 0 = write ALU result`
- `func  out  FUNC_W  ALU function`
- `constant  out  DATA_W  immediate write data`
- `busy  out  1  operation in progress`
- `done  out  1  one-cycle completion pulse; result readable on datapath port 1`
- `err  out  1  one-cycle pulse with done when the watchdog expired`

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, CMP, SUB_AB, SUB_BA, DONE.
- Outputs are a Moore decode of the registered state and latched operands. In IDLE every output is 0 except `func = FUNC_NOP`.
- **IDLE:** if `start` is high, latch `op_a`/`op_b`, clear the iteration counter, and go to LOAD_A.
- **LOAD_A:** `wen = 1`, `waddr = REG_A`, `wdsrc = 1`.
  - `constant = op_a`, or `op_b` if `op_a == 0`.
  - If either operand is 0, go to DONE; the result is the other operand, and gcd(0,0) = 0.
  - Otherwise go to LOAD_B.
- **LOAD_B:** `wen = 1`, `waddr = REG_B`, `wdsrc = 1`, `constant = op_b`. Go to CMP.
- **CMP:** `raddr1 = REG_A`, `raddr2 = REG_B`, `func = FUNC_SUB`, `wen = 0`. Priority order:
  - `is_zero` → DONE.
  - Counter at its limit → DONE with `err`.
  - `is_neg` → SUB_BA.
  - Otherwise → SUB_AB.
  - The counter increments on every CMP exit to a SUB state and saturates; it never wraps.
- **SUB_AB:** `raddr1 = REG_A`, `raddr2 = REG_B`, `func = FUNC_SUB`, `wen = 1`, `waddr = REG_A`, `wdsrc = 0`. Go to CMP.
- **SUB_BA:** `raddr1 = REG_B`, `raddr2 = REG_A`, `func = FUNC_SUB`, `wen = 1`, `waddr = REG_B`, `wdsrc = 0`. Go to CMP.
- **DONE:** `raddr1 = REG_A`, `done = 1`, `err` as recorded. Go to IDLE.
- `busy` = state ≠ IDLE.
- `start` while busy is ignored and not queued.

## Timing
- Reset (asynchronous assert, synchronous deassert by the environment) forces IDLE from any state. The counter and latches clear, and every output takes its IDLE value immediately, including mid-operation. An interrupted register-file write does not happen after reset asserts.
- Start accepted on edge N: LOAD_A at N+1, LOAD_B at N+2, first CMP at N+3.
- Latency with k subtract steps: `done` high in cycle N+4+2k. With a zero operand, `done` is high in cycle N+2.
- `start` high in the DONE cycle is ignored. `start` high in the following IDLE cycle is accepted (back-to-back spacing of one idle cycle).
- `is_zero` and `is_neg` are sampled only at the clock edge ending CMP. Their values in other states are don't-care.

## Structure
- `gcd_pkg` contains:
  - the state enum;
  - ALU function codes, with `FUNC_SUB`/`FUNC_NOP` defaults sourced from it;
  - `wdsrc` encodings (`WDSRC_ALU = 0`, `WDSRC_CONST = 1`).
- Single module, no sub-module. The watchdog is a plain saturating counter inside the block.

## Test plan
- Reset, then idle: all outputs 0, `func = FUNC_NOP`, `busy = 0`. Assert `rst_n` low mid-CMP → outputs go to IDLE values with no clock.
- `op_a = 12`, `op_b = 8` against a behavioural datapath → state sequence LA, LB, CMP, SUB_AB, CMP, SUB_BA, CMP, DONE. `done` at N+8, REG_A = 4, `err = 0`.
- `op_a = 0`, `op_b = 9` → LOAD_A writes 9 to REG_A, `done` at N+2. Also `op_a = op_b = 0` → result 0.
- `op_a = 7`, `op_b = 7` → one CMP, `done` at N+4, result 7. Pulse `start` during `busy` → no effect on sequence or operands.
- `ITER_W = 3`, `op_a = 100`, `op_b = 1` → `done` and `err` pulse together after 7 subtract steps, then IDLE.
- Random 16-bit operand pairs (≥ 1000) → REG_A at `done` equals reference gcd. Latency matches N+4+2k.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and encodings for the GCD sequencer.
package gcd_pkg;

   // Sequencer states.
   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StLoadB,
      StCmp,
      StSubAb,
      StSubBa,
      StDone
   } gcd_state_e;

   // ALU function codes understood by the datapath.
   localparam int unsigned ALU_NOP = 0;
   localparam int unsigned ALU_SUB = 1;

   // Write-data source select.
   localparam logic WDSRC_ALU   = 1'b0;
   localparam logic WDSRC_CONST = 1'b1;

endpackage

// File: rtl/gcd_seq_ctrl_if.sv
// Control-word and handshake bundle between the GCD sequencer and its host/datapath.
interface gcd_seq_ctrl_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned FUNC_W = 4
);
   logic              start;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              is_zero;
   logic              is_neg;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic              wen;
   logic [ADDR_W-1:0] waddr;
   logic              wdsrc;
   logic [FUNC_W-1:0] func;
   logic [DATA_W-1:0] constant;
   logic              busy;
   logic              done;
   logic              err;

   // Host and datapath side: requests work, supplies ALU flags.
   modport master (
      output start, op_a, op_b, is_zero, is_neg,
      input  raddr1, raddr2, wen, waddr, wdsrc, func, constant, busy, done, err
   );

   // Sequencer side.
   modport slave (
      input  start, op_a, op_b, is_zero, is_neg,
      output raddr1, raddr2, wen, waddr, wdsrc, func, constant, busy, done, err
   );
endinterface

// File: rtl/gcd_seq_ctrl.sv
// Subtractive-Euclid sequencer that drives the GCD register-file/ALU datapath.
// All outputs are registered: the next-state decode is computed combinationally and
// captured together with the state, so the control word is glitch-free.
module gcd_seq_ctrl
   import gcd_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned FUNC_W   = 4,
   parameter int unsigned REG_A    = 0,
   parameter int unsigned REG_B    = 1,
   parameter int unsigned FUNC_SUB = ALU_SUB,
   parameter int unsigned FUNC_NOP = ALU_NOP,
   parameter int unsigned ITER_W   = 16
) (
   input logic           clk,
   input logic           rst_n,
   gcd_seq_ctrl_if.slave bus
);

   localparam logic [ADDR_W-1:0] AddrA   = ADDR_W'(REG_A);
   localparam logic [ADDR_W-1:0] AddrB   = ADDR_W'(REG_B);
   localparam logic [FUNC_W-1:0] FuncSub = FUNC_W'(FUNC_SUB);
   localparam logic [FUNC_W-1:0] FuncNop = FUNC_W'(FUNC_NOP);
   localparam logic [ITER_W-1:0] IterMax = '1;

   gcd_state_e        state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              err_q, err_d;

   logic [ADDR_W-1:0] raddr1_q, raddr1_d;
   logic [ADDR_W-1:0] raddr2_q, raddr2_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              wdsrc_q, wdsrc_d;
   logic [FUNC_W-1:0] func_q, func_d;
   logic [DATA_W-1:0] const_q, const_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              errp_q, errp_d;

   // Next state, operand latches and watchdog.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      iter_d  = iter_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               iter_d  = '0;
               err_d   = 1'b0;
               state_d = StLoadA;
            end
         end
         StLoadA: begin
            // A zero operand makes the other one the answer; nothing to iterate.
            state_d = (a_q == '0 || b_q == '0) ? StDone : StLoadB;
         end
         StLoadB: state_d = StCmp;
         StCmp: begin
            if (bus.is_zero) begin
               state_d = StDone;
            end else if (iter_q == IterMax) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else begin
               // Below IterMax here, so the increment cannot wrap.
               iter_d  = iter_q + 1'b1;
               state_d = bus.is_neg ? StSubBa : StSubAb;
            end
         end
         StSubAb: state_d = StCmp;
         StSubBa: state_d = StCmp;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Moore decode of the upcoming state, to be registered alongside it.
   always_comb begin
      raddr1_d = '0;
      raddr2_d = '0;
      wen_d    = 1'b0;
      waddr_d  = '0;
      wdsrc_d  = WDSRC_ALU;
      func_d   = FuncNop;
      const_d  = '0;
      busy_d   = (state_d != StIdle);
      done_d   = 1'b0;
      errp_d   = 1'b0;
      unique case (state_d)
         StIdle: ;
         StLoadA: begin
            wen_d   = 1'b1;
            waddr_d = AddrA;
            wdsrc_d = WDSRC_CONST;
            const_d = (a_d == '0) ? b_d : a_d;
         end
         StLoadB: begin
            wen_d   = 1'b1;
            waddr_d = AddrB;
            wdsrc_d = WDSRC_CONST;
            const_d = b_d;
         end
         StCmp: begin
            raddr1_d = AddrA;
            raddr2_d = AddrB;
            func_d   = FuncSub;
         end
         StSubAb: begin
            raddr1_d = AddrA;
            raddr2_d = AddrB;
            func_d   = FuncSub;
            wen_d    = 1'b1;
            waddr_d  = AddrA;
         end
         StSubBa: begin
            raddr1_d = AddrB;
            raddr2_d = AddrA;
            func_d   = FuncSub;
            wen_d    = 1'b1;
            waddr_d  = AddrB;
         end
         StDone: begin
            raddr1_d = AddrA;
            done_d   = 1'b1;
            errp_d   = err_d;
         end
         default: ;
      endcase
   end

   // State and registered control word; reset forces the idle word at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         iter_q   <= '0;
         err_q    <= 1'b0;
         raddr1_q <= '0;
         raddr2_q <= '0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdsrc_q  <= WDSRC_ALU;
         func_q   <= FuncNop;
         const_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         errp_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         iter_q   <= iter_d;
         err_q    <= err_d;
         raddr1_q <= raddr1_d;
         raddr2_q <= raddr2_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdsrc_q  <= wdsrc_d;
         func_q   <= func_d;
         const_q  <= const_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         errp_q   <= errp_d;
      end
   end

   assign bus.raddr1   = raddr1_q;
   assign bus.raddr2   = raddr2_q;
   assign bus.wen      = wen_q;
   assign bus.waddr    = waddr_q;
   assign bus.wdsrc    = wdsrc_q;
   assign bus.func     = func_q;
   assign bus.constant = const_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = errp_q;

endmodule
